// File: rtl/seg7_pkg.sv
// seg7_scan_driver shared definitions: blank pattern,
// 16-entry segment table and the nibble decode helper.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // {a,b,c,d,e,f,g}, active-low; entry 0 is the rightmost slice
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  function automatic logic [6:0] seg7_decode(
    input logic [3:0] nib,
    input logic       hex_en
  );
    if (!hex_en && (nib > 4'd9)) return SEG_OFF;
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Refresh prescaler and digit index for the scan driver.
// tick marks the last cycle of each digit slot.
module seg7_prescaler
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int PW = $clog2(REFRESH_DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          tick,
  output logic [IW-1:0] idx,
  output logic [PW-1:0] cnt
);

  logic [PW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;

  // wrap the prescaler and advance the digit on terminal count
  always_comb begin
    tick  = (cnt_q == PW'(REFRESH_DIV - 1));
    cnt_d = cnt_q + PW'(1);
    idx_d = idx_q;
    if (tick) begin
      cnt_d = '0;
      if (idx_q == IW'(NUM_DIGITS - 1)) idx_d = '0;
      else                              idx_d = idx_q + IW'(1);
    end
  end

  // counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign idx = idx_q;
  assign cnt = cnt_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver with registered pins.
// Define SEG7_BLANKING_EN for an anode-off tail in each slot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    hex_en,
  input  logic                    blank_lead,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(REFRESH_DIV);

  logic          tick;
  logic [IW-1:0] idx;
  logic [PW-1:0] cnt;

  seg7_prescaler #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .idx   (idx),
    .cnt   (cnt)
  );

  logic unused_ok;
  assign unused_ok = ^{tick, cnt};

  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   dps_q, dps_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic       run, supp, dp_sel;
  logic [3:0] nib;

  // shadow capture and next pin values for the selected digit
  always_comb begin
    shadow_d = load ? value : shadow_q;
    dps_d    = load ? dp_in : dps_q;
    run      = 1'b1;
    supp     = 1'b0;
    nib      = 4'd0;
    dp_sel   = 1'b0;
    an_d     = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run = run & (shadow_q[4*i +: 4] == 4'd0);
      if (idx == IW'(i)) begin
        nib     = shadow_q[4*i +: 4];
        dp_sel  = dps_q[i];
        an_d[i] = 1'b0;
        supp    = blank_lead && (i > 0) && run;
      end
    end
    seg_d = seg7_decode(nib, hex_en);
    dp_d  = ~dp_sel;
    if (supp) begin
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      an_d  = '1;
    end
`ifdef SEG7_BLANKING_EN
    if (cnt >= PW'(REFRESH_DIV - BLANK_CYCLES)) an_d = '1;
`endif
  end

  // shadow and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      dps_q    <= '0;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
      an_q     <= '1;
    end else begin
      shadow_q <= shadow_d;
      dps_q    <= dps_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
    end
  end

  assign seg_n = seg_q;
  assign dp_n  = dp_q;
  assign an_n  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised bench for seg7_scan_driver against a
// slot-arithmetic reference model (4 digits, div 4).
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load, hex_en, blank_lead;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;

  seg7_scan_driver #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp_in      (dp_in),
    .load       (load),
    .hex_en     (hex_en),
    .blank_lead (blank_lead),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  logic [6:0] segs [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // model state: edges since reset release, shadow copies
  int          edges;
  logic [15:0] m_val;
  logic [3:0]  m_dp;

  // pins after edge number e: {an_n, dp_n, seg_n}
  function automatic logic [11:0] model(
    input int e, input logic [15:0] v, input logic [3:0] d,
    input logic hx, input logic bl);
    int         k = (e / 4) % 4;
    logic [15:0] up = v >> (4 * k);
    logic [3:0] nib = up[3:0];
    logic [3:0] an = 4'hF;
    logic [6:0] s;
    if (bl && k > 0 && up == 16'd0) return 12'hFFF;
    s = (nib > 4'd9 && !hx) ? 7'h7F : segs[nib];
    an[k] = 1'b0;
`ifdef SEG7_BLANKING_EN
    if (e % 4 == 3) an = 4'hF;
`endif
    return {an, ~d[k], s};
  endfunction

  // one clock with the currently driven inputs, then compare
  task automatic step(input string tag);
    logic [11:0] exp;
    exp = model(edges, m_val, m_dp, hex_en, blank_lead);
    @(posedge clk);
    if (load) begin
      m_val = value;
      m_dp  = dp_in;
    end
    edges++;
    @(negedge clk);
    check(tag, {20'd0, an_n, dp_n, seg_n}, {20'd0, exp});
  endtask

  task automatic do_load(input logic [15:0] v,
                         input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    step("load");
    load = 1'b0;
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic reset_release();
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    m_val = 16'd0;
    m_dp  = 4'd0;
  endtask

  initial begin
    rst_n = 1'b0; value = '0; dp_in = '0; load = 1'b0;
    hex_en = 1'b0; blank_lead = 1'b0;
    edges = 0; m_val = '0; m_dp = '0;
    repeat (2) @(negedge clk);
    check("rst_pins", {20'd0, an_n, dp_n, seg_n}, 32'hFFF);
    reset_release();
    step("first_out");
    run("zero", 5);

    do_load(16'h1234, 4'b0000);
    run("bcd1234", 20);

    do_load(16'h00AF, 4'b0000);
    run("bcd_AF", 16);
    hex_en = 1'b1;
    run("hex_AF", 16);
    hex_en = 1'b0;

    blank_lead = 1'b1;
    do_load(16'h0050, 4'b0000);
    run("lz0050", 16);
    do_load(16'h0000, 4'b0000);
    run("lz0000", 16);
    blank_lead = 1'b0;

    do_load(16'h1234, 4'b0100);
    run("dp", 16);
    blank_lead = 1'b1;
    do_load(16'h0001, 4'b0100);
    run("dp_supp", 16);
    blank_lead = 1'b0;

    do_load(16'h1234, 4'b0000);
    while (edges % 4 != 3) step("align");
    do_load(16'h5678, 4'b0000);
    run("tc_load", 16);

    // asynchronous reset in the middle of a cycle
    #2 rst_n = 1'b0;
    #1 check("rst_async", {20'd0, an_n, dp_n, seg_n}, 32'hFFF);
    reset_release();
    step("rst_rel");
    run("post_rst", 7);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        logic [15:0] mask;
        case ($urandom_range(0, 3))
          0: mask = 16'hFFFF;
          1: mask = 16'h00FF;
          2: mask = 16'h000F;
          default: mask = 16'h0000;
        endcase
        value = 16'($urandom) & mask;
        dp_in = 4'($urandom);
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 15) == 0) hex_en = ~hex_en;
      if ($urandom_range(0, 15) == 0) blank_lead = ~blank_lead;
      step("rand");
    end
    load = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
